// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and its pending-write scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and architectural register count
//   word_t               : one register-sized data word
//   addr_width()         : register-address width for a given register count
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0] word_t;

  // Never returns 0, so a 1-register corner still gets a legal address bus.
  function automatic int unsigned addr_width(int unsigned nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   iss_valid, iss_rd   : decode issues a producer for register iss_rd (sets busy)
//   wr_valid, wr_rd     : writeback retires the producer of register wr_rd (clears busy)
//   flush               : drop every pending bit, except one being set this cycle
//   busy                : one pending bit per register
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wr_valid,
  input  logic [AW-1:0]    wr_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      set_vec[r] = iss_valid && (iss_rd == AW'(r));
      clr_vec[r] = wr_valid && (wr_rd == AW'(r));
    end
    // A hardwired zero register never has a pending producer.
    if (ZERO_REG) begin
      set_vec[0] = 1'b0;
    end
    // A new producer outranks both a retiring one and a flush.
    if (flush) begin
      busy_d = set_vec;
    end else begin
      busy_d = (busy_q & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port integer register file with write-through bypass and a pending-write
// scoreboard for decode hazard detection.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   regwrite/waddr/wdata: writeback port
//   raddr / rdata       : NRD combinational read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rready              : per-port operand valid (not pending, or bypassed this cycle)
//   iss_valid / iss_rd  : decode marks a destination register as pending
//   flush               : clear all pending bits
//   busy                : pending-write bit per register
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwrite,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rready,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_en;
  logic [NREGS-1:0] busy_vec;

  // Writes to a hardwired x0 are dropped; they must not bypass either.
  assign wr_en = regwrite && !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wr_valid  (regwrite),
    .wr_rd     (waddr),
    .flush     (flush),
    .busy      (busy_vec)
  );

  assign busy = busy_vec;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_x0;
    logic          hit;

    assign ra    = raddr[g*AW +: AW];
    assign is_x0 = ZERO_REG && (ra == '0);
    assign hit   = wr_en && (waddr == ra);

    // Reset masks the bypass path so a write presented during reset never leaks out.
    assign rdata[g*XLEN +: XLEN] = (rst || is_x0) ? '0    :
                                   hit            ? wdata :
                                                    mem_q[ra];
    assign rready[g] = rst || is_x0 || !busy_vec[ra] || hit;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: a default instance (2 ports, 32 regs, hardwired
// x0) and a wide instance (3 ports, 64 regs, ordinary x0), both compared every cycle against
// an array-based reference model, with directed scenarios followed by random traffic.
module tb_register_file_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance.
  logic        a_regwrite, a_iss_valid, a_flush;
  logic [4:0]  a_waddr, a_iss_rd;
  logic [31:0] a_wdata, a_busy;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rready;

  // Wide instance.
  logic        b_regwrite, b_iss_valid, b_flush;
  logic [5:0]  b_waddr, b_iss_rd;
  logic [31:0] b_wdata;
  logic [63:0] b_busy;
  logic [17:0] b_raddr;
  logic [95:0] b_rdata;
  logic [2:0]  b_rready;

  register_file_sb dut0 (
    .clk(clk), .rst(rst), .regwrite(a_regwrite), .waddr(a_waddr), .wdata(a_wdata),
    .raddr(a_raddr), .rdata(a_rdata), .rready(a_rready), .iss_valid(a_iss_valid),
    .iss_rd(a_iss_rd), .flush(a_flush), .busy(a_busy)
  );

  register_file_sb #(.NREGS(64), .NRD(3), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .rst(rst), .regwrite(b_regwrite), .waddr(b_waddr), .wdata(b_wdata),
    .raddr(b_raddr), .rdata(b_rdata), .rready(b_rready), .iss_valid(b_iss_valid),
    .iss_rd(b_iss_rd), .flush(b_flush), .busy(b_busy)
  );

  // Reference model: plain arrays of register contents and pending flags.
  logic [31:0] m0_mem [32];
  bit          m0_busy[32];
  logic [31:0] m1_mem [64];
  bit          m1_busy[64];

  int n_cmp;
  int n_bad;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int r = 0; r < 32; r++) begin m0_mem[r] = '0; m0_busy[r] = 1'b0; end
    for (int r = 0; r < 64; r++) begin m1_mem[r] = '0; m1_busy[r] = 1'b0; end
  endtask

  function automatic logic [31:0] exp0_rdata(int p);
    logic [4:0] a;
    a = a_raddr[p*5 +: 5];
    if (rst || a == 5'd0) return '0;
    if (a_regwrite && a_waddr == a) return a_wdata;
    return m0_mem[a];
  endfunction

  function automatic logic exp0_rready(int p);
    logic [4:0] a;
    a = a_raddr[p*5 +: 5];
    if (rst || a == 5'd0) return 1'b1;
    return !m0_busy[a] || (a_regwrite && a_waddr == a);
  endfunction

  function automatic logic [31:0] exp1_rdata(int p);
    logic [5:0] a;
    a = b_raddr[p*6 +: 6];
    if (rst) return '0;
    if (b_regwrite && b_waddr == a) return b_wdata;
    return m1_mem[a];
  endfunction

  function automatic logic exp1_rready(int p);
    logic [5:0] a;
    a = b_raddr[p*6 +: 6];
    if (rst) return 1'b1;
    return !m1_busy[a] || (b_regwrite && b_waddr == a);
  endfunction

  function automatic logic [63:0] exp0_busy();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 32; r++) v[r] = m0_busy[r];
    return v;
  endfunction

  function automatic logic [63:0] exp1_busy();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 64; r++) v[r] = m1_busy[r];
    return v;
  endfunction

  // Pending-bit rule: a new producer wins; otherwise flush or retirement clears; else hold.
  function automatic bit nxt_busy(bit cur, bit set, bit clr, bit fl);
    if (set) return 1'b1;
    if (fl || clr) return 1'b0;
    return cur;
  endfunction

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("d0_rdata%0d", p), 64'(a_rdata[p*32 +: 32]), 64'(exp0_rdata(p)));
      chk($sformatf("d0_rready%0d", p), 64'(a_rready[p]), 64'(exp0_rready(p)));
    end
    chk("d0_busy", 64'(a_busy), exp0_busy());
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("d1_rdata%0d", p), 64'(b_rdata[p*32 +: 32]), 64'(exp1_rdata(p)));
      chk($sformatf("d1_rready%0d", p), 64'(b_rready[p]), 64'(exp1_rready(p)));
    end
    chk("d1_busy", b_busy, exp1_busy());
  endtask

  // Advance both models by one clock edge using the inputs currently applied.
  task automatic model_update();
    bit s, c;
    if (rst) begin
      clear_models();
      return;
    end
    for (int r = 0; r < 32; r++) begin
      s = a_iss_valid && int'(a_iss_rd) == r && r != 0;
      c = a_regwrite && int'(a_waddr) == r;
      m0_busy[r] = nxt_busy(m0_busy[r], s, c, a_flush);
    end
    if (a_regwrite && a_waddr != 5'd0) m0_mem[a_waddr] = a_wdata;
    for (int r = 0; r < 64; r++) begin
      s = b_iss_valid && int'(b_iss_rd) == r;
      c = b_regwrite && int'(b_waddr) == r;
      m1_busy[r] = nxt_busy(m1_busy[r], s, c, b_flush);
    end
    if (b_regwrite) m1_mem[b_waddr] = b_wdata;
  endtask

  // Check combinational outputs mid-cycle, then step through the next rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_regwrite = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    a_iss_valid = 1'b0; a_iss_rd = '0; a_flush = 1'b0;
    b_regwrite = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
    b_iss_valid = 1'b0; b_iss_rd = '0; b_flush = 1'b0;
  endtask

  // Bias addresses toward a small window so hits, bypasses and collisions are frequent.
  function automatic logic [5:0] pick_addr(int unsigned maxv);
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, maxv));
    return 6'($urandom_range(0, 7));
  endfunction

  task automatic drive_random();
    logic [5:0] rd;
    a_regwrite = 1'($urandom_range(0, 1));
    a_waddr    = 5'(pick_addr(31));
    a_wdata    = $urandom;
    a_raddr    = {5'(pick_addr(31)), 5'(pick_addr(31))};
    a_flush    = ($urandom_range(0, 15) == 0);
    rd         = pick_addr(31);
    a_iss_rd   = 5'(rd);
    // Decode never issues a destination that is still pending.
    a_iss_valid = ($urandom_range(0, 1) == 1) && !m0_busy[rd[4:0]];
    b_regwrite = 1'($urandom_range(0, 1));
    b_waddr    = pick_addr(63);
    b_wdata    = $urandom;
    b_raddr    = {pick_addr(63), pick_addr(63), pick_addr(63)};
    b_flush    = ($urandom_range(0, 15) == 0);
    rd         = pick_addr(63);
    b_iss_rd   = rd;
    b_iss_valid = ($urandom_range(0, 1) == 1) && !m1_busy[rd];
    rst        = ($urandom_range(0, 63) == 0);
    if (rst) clear_models();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    clear_models();
    // Reset state, with a write and issue presented that must be ignored.
    rst = 1'b1;
    a_regwrite = 1'b1; a_waddr = 5'd5; a_wdata = 32'hCAFE_F00D; a_raddr = {5'd0, 5'd5};
    a_iss_valid = 1'b1; a_iss_rd = 5'd5;
    #2;
    check_all();
    chk("rst_rdata", 64'(a_rdata), 64'd0);
    chk("rst_rready", 64'(a_rready), 64'd3);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Bypass, then stored value.
    a_regwrite = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1234; a_raddr = {5'd0, 5'd7};
    #1;
    chk("byp_rdata", 64'(a_rdata[31:0]), 64'h1234);
    chk("byp_rready", 64'(a_rready[0]), 64'd1);
    tick();
    idle(); a_raddr = {5'd0, 5'd7};
    #1;
    chk("byp_stored", 64'(a_rdata[31:0]), 64'h1234);
    tick();

    // Asynchronous reset mid-run.
    a_regwrite = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
    a_iss_valid = 1'b1; a_iss_rd = 5'd6;
    tick();
    idle(); a_raddr = {5'd6, 5'd5};
    #1;
    chk("x5_written", 64'(a_rdata[31:0]), 64'hDEAD_BEEF);
    rst = 1'b1;
    clear_models();
    #1;
    check_all();
    chk("arst_rdata", 64'(a_rdata[31:0]), 64'd0);
    chk("arst_busy", 64'(a_busy), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_x5", 64'(a_rdata[31:0]), 64'd0);

    // Hardwired x0.
    idle();
    a_regwrite = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF;
    a_iss_valid = 1'b1; a_iss_rd = 5'd0;
    tick();
    idle();
    #1;
    chk("x0_rdata", 64'(a_rdata[31:0]), 64'd0);
    chk("x0_busy", 64'(a_busy[0]), 64'd0);
    chk("x0_rready", 64'(a_rready[0]), 64'd1);
    tick();

    // Scoreboard set, then retire with bypass.
    a_iss_valid = 1'b1; a_iss_rd = 5'd3;
    tick();
    idle(); a_raddr = {5'd0, 5'd3};
    #1;
    chk("sb_busy3", 64'(a_busy[3]), 64'd1);
    chk("sb_stall", 64'(a_rready[0]), 64'd0);
    tick();
    a_regwrite = 1'b1; a_waddr = 5'd3; a_wdata = 32'h55;
    #1;
    chk("sb_wb_rready", 64'(a_rready[0]), 64'd1);
    chk("sb_wb_rdata", 64'(a_rdata[31:0]), 64'h55);
    tick();
    idle();
    #1;
    chk("sb_retired", 64'(a_busy[3]), 64'd0);

    // Issue/retire collision, then flush with a same-cycle issue.
    a_iss_valid = 1'b1; a_iss_rd = 5'd2;
    tick();
    a_iss_valid = 1'b1; a_iss_rd = 5'd9;
    a_regwrite = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
    tick();
    idle();
    #1;
    chk("coll_busy9", 64'(a_busy[9]), 64'd1);
    a_flush = 1'b1; a_iss_valid = 1'b1; a_iss_rd = 5'd4;
    tick();
    idle();
    #1;
    chk("flush_busy", 64'(a_busy), 64'h10);

    // Wide instance: ordinary x0 and a double-port bypass.
    b_regwrite = 1'b1; b_waddr = 6'd0; b_wdata = 32'hA5;
    tick();
    b_regwrite = 1'b1; b_waddr = 6'd10; b_wdata = 32'h1010;
    b_raddr = {6'd0, 6'd10, 6'd10};
    #1;
    chk("w_byp0", 64'(b_rdata[31:0]), 64'h1010);
    chk("w_byp1", 64'(b_rdata[63:32]), 64'h1010);
    chk("w_x0", 64'(b_rdata[95:64]), 64'hA5);
    tick();
    idle();
    b_iss_valid = 1'b1; b_iss_rd = 6'd0;
    tick();
    idle();
    #1;
    chk("w_x0_busy", 64'(b_busy[0]), 64'd1);
    chk("w_x0_stall", 64'(b_rready[0]), 64'd0);
    tick();

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      drive_random();
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
